// File: rtl/dmem_access_ctrl_if.sv
// Request/response bundle for both word ports plus the byte-memory side of dmem_access_ctrl.
interface dmem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              req0;
  logic              we0;
  logic [31:0]       addr0;
  logic [31:0]       wdata0;
  logic              ack0;
  logic [31:0]       rdata0;
  logic              req1;
  logic              we1;
  logic [31:0]       addr1;
  logic [31:0]       wdata1;
  logic              ack1;
  logic [31:0]       rdata1;
  logic              busy;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output ack0, rdata0, ack1, rdata1, busy, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  ack0, rdata0, ack1, rdata1, busy, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Two-port round-robin arbiter that serialises 32-bit word accesses into four
// big-endian byte beats on a single-ported byte memory.
module dmem_access_ctrl #(
  parameter int unsigned ADDR_W = 10
) (
  input logic               clk,
  input logic               reset,
  dmem_access_ctrl_if.slave bus
);
  localparam int unsigned WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t          state;
  logic [1:0]      k;
  logic            last;
  logic            port;
  logic            we_q;
  logic [WA_W-1:0] waddr;
  logic [31:0]     wdata_q;
  logic [31:0]     rbuf;

  logic            pend_c;
  logic            gnt_c;
  logic            sel_we_c;
  logic [WA_W-1:0] sel_waddr_c;
  logic [31:0]     sel_wdata_c;
  logic [1:0]      k_nxt_c;
  logic [31:0]     rword_c;
  logic            unused_c;

  // Arbitration, request mux and read-buffer merge of the current byte
  always_comb begin
    pend_c      = bus.req0 | bus.req1;
    gnt_c       = (bus.req0 & bus.req1) ? ~last : bus.req1;
    sel_we_c    = gnt_c ? bus.we1 : bus.we0;
    sel_waddr_c = gnt_c ? bus.addr1[ADDR_W-1:2] : bus.addr0[ADDR_W-1:2];
    sel_wdata_c = gnt_c ? bus.wdata1 : bus.wdata0;
    k_nxt_c     = k + 2'd1;
    rword_c     = rbuf;
    rword_c[{~k, 3'b000} +: 8] = bus.mem_rdata;
  end

  // Byte-offset and above-ADDR_W address bits are intentionally dropped
  assign unused_c = ^{bus.addr0[31:ADDR_W], bus.addr0[1:0],
                      bus.addr1[31:ADDR_W], bus.addr1[1:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      k             <= 2'd0;
      last          <= 1'b1;
      port          <= 1'b0;
      we_q          <= 1'b0;
      waddr         <= '0;
      wdata_q       <= '0;
      rbuf          <= '0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.busy      <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_c) begin
            state         <= BEAT;
            k             <= 2'd0;
            port          <= gnt_c;
            last          <= gnt_c;
            we_q          <= sel_we_c;
            waddr         <= sel_waddr_c;
            wdata_q       <= sel_wdata_c;
            bus.busy      <= 1'b1;
            bus.mem_we    <= sel_we_c;
            bus.mem_addr  <= {sel_waddr_c, 2'b00};
            bus.mem_wdata <= sel_we_c ? sel_wdata_c[31:24] : 8'h00;
          end
        end
        BEAT: begin
          if (!we_q) rbuf <= rword_c;
          if (k == 2'd3) begin
            // Last byte is merged straight into rdata so it is valid with ack
            state         <= DONE;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            if (port) begin
              bus.ack1 <= 1'b1;
              if (!we_q) bus.rdata1 <= rword_c;
            end else begin
              bus.ack0 <= 1'b1;
              if (!we_q) bus.rdata0 <= rword_c;
            end
          end else begin
            k             <= k_nxt_c;
            bus.mem_addr  <= {waddr, k_nxt_c};
            bus.mem_wdata <= we_q ? wdata_q[{~k_nxt_c, 3'b000} +: 8] : 8'h00;
          end
        end
        DONE: begin
          state    <= IDLE;
          k        <= 2'd0;
          bus.ack0 <= 1'b0;
          bus.ack1 <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Sequencing controller and two-port arbiter for the byte-organised data memory. It serves word (32-bit) load/store requests from the CPU datapath (port 0) and from the program/data loader (port 1). Each granted word is serialised into four byte beats on a single-ported byte memory, stored big-endian (MSB at the lowest byte address). It sits between the datapath's load/store path and the data memory array.

## Interface
- `ADDR_W`, 10: byte-address width of the memory; 1024 bytes at default.
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: synchronous reset, active-high.
- `req0` in 1: CPU request, level; held until `ack0`.
- `we0` in 1: CPU write (1) / read (0).
- `addr0` in 32: CPU byte address.
- `wdata0` in 32: CPU store data.
- `ack0` out 1: one-cycle completion pulse for port 0.
- `rdata0` out 32: port 0 load data; valid in the `ack0` cycle.
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rdata1`: identical set for the loader, port 1.
- `busy` out 1: high in any state other than IDLE.
- `mem_we` out 1: byte write strobe to the memory array.
- `mem_addr` out ADDR_W: byte address to the memory array.
- `mem_wdata` out 8: byte write data.
- `mem_rdata` in 8: byte read data, combinational from `mem_addr`.

## Operation
- FSM states are IDLE, BEAT, DONE, with a 2-bit beat counter `k`.
- **IDLE:**
  - If a request is pending, the arbiter picks a winner.
  - The winner's `we`, address and `wdata` are latched, `k` is set to 0, and the FSM goes to BEAT.
- **Arbitration:** round-robin between two ports.
  - A 1-bit `last` pointer records the most recently granted port.
  - If both ports request in the same cycle, the port not equal to `last` wins.
  - After reset, `last` = 1, so port 0 wins the first tie.
- **Address handling:**
  - Latched word address = `addr[ADDR_W-1:2]`. `addr[1:0]` is ignored (forced aligned).
  - Upper bits above `ADDR_W` are ignored, so the address wraps modulo 2^ADDR_W.
- **BEAT:**
  - `mem_addr` = {word address, `k`}.
  - On a write: `mem_we` = 1 and `mem_wdata` = latched `wdata[31-8k -: 8]`.
  - On a read: `mem_rdata` is captured into byte lane `31-8k` of the read buffer at the end of the cycle.
  - `k` increments each cycle. After `k` = 3 the FSM goes to DONE.
- **DONE:**
  - `ack` of the granted port = 1.
  - That port's `rdata` register is loaded from the read buffer. For writes, `rdata` is unchanged.
  - Next state is IDLE.
- **Latching rules:**
  - Requester inputs are sampled only in IDLE; changes during BEAT/DONE are ignored.
  - The requester must drop `req` on the edge after `ack`. If `req` is still high in the following IDLE cycle, it is treated as a new request.
- **Output defaults:**
  - `mem_we` = 0 in every state except write BEAT.
  - `mem_addr` and `mem_wdata` hold 0 in IDLE/DONE.
- **Reset:**
  - All outputs = 0, FSM = IDLE, `k` = 0, `last` = 1, read buffer = 0.
  - Reset asserted mid-transaction aborts it with no `ack`. Bytes already written stay written (partial word permitted, documented).

## Timing
- Let cycle N be an IDLE cycle with `req` high.
  - Cycles N+1..N+4: BEAT `k` = 0..3.
  - Cycle N+5: DONE, `ack` high.
  - Cycle N+6: IDLE.
- Latency is 5 cycles from request sample to `ack`. Peak throughput is one word per 6 cycles.
- Byte writes commit at the rising edge ending each write BEAT cycle.
- With both ports continuously requesting, grants alternate 0, 1, 0, 1. Worst-case wait for a port is 6 cycles.
- `busy` is high for N+1..N+5.
- Exactly one `ack` pulse per granted transaction. `ack0` and `ack1` are never high together.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` for 2 cycles with random inputs.
  - Required: all outputs 0, `busy` = 0, no memory writes.
- **Port 0 store/load:**
  - Stimulus: store `addr0` = 0x0000_0010, `wdata0` = 0xDEADBEEF.
  - Required: bytes 0x10..0x13 = DE, AD, BE, EF, and `ack0` at N+5.
  - Stimulus: load from the same address.
  - Required: `rdata0` = 0xDEADBEEF with `ack0`.
- **Alignment and wrap:**
  - Stimulus: port 1 stores 0x01020304 at `addr1` = 0xFFFF_F3FF, with `ADDR_W` = 10.
  - Required: bytes written at 0x3FC..0x3FF.
  - Stimulus: port 0 loads at 0x3FD.
  - Required: returns 0x01020304.
- **Simultaneous requests after reset:**
  - Stimulus: both ports request in the same cycle, held continuously.
  - Required: grant order 0, 1, 0, 1, with `ack`s at 6-cycle spacing and never coincident.
- **Input stability:**
  - Stimulus: change `addr0`/`wdata0` during BEAT.
  - Required: memory receives the originally latched word; the new values are ignored.
- **Reset mid-write:**
  - Stimulus: reset during BEAT `k` = 2 of a 0xAABBCCDD store to a word that was previously 0.
  - Required: bytes AA, BB, 00, 00, no `ack`, FSM in IDLE.
